pixel_packer: RTL and testbench
===============================

Name: pixel_packer

Overview:
- Camera-side stage directly upstream of the DDR3 write path.
- Runs in the DDR3 UI clock domain, after the camera CDC FIFO.
- Collects 16-bit RGB565 pixels from the camera stream and packs 8 consecutive pixels into one 128-bit word.
- Presents packed words on an AXI-Stream master, frame-aligned, with tlast on the final word of each frame; this feeds the write AXIS FIFO drained by the memory traffic generator.

Parameters:
- FRAME_WORDS, 115200, number of 128-bit words per frame (1280*720/8).
- COUNT_WIDTH, 17, width of the word counter; must satisfy 2^COUNT_WIDTH >= FRAME_WORDS.

Ports:
- clk_in  input  1  clock; single clock domain.
- rst_in  input  1  synchronous, active-high reset.
- pixel_data_in  input  16  RGB565 pixel.
- pixel_valid_in  input  1  pixel_data_in is valid this cycle; no backpressure, pixels are never stalled.
- frame_start_in  input  1  qualifies the current valid pixel as pixel 0 of a frame; ignored when pixel_valid_in=0.
- chunk_axis_data  output  128  packed word; pixel k occupies bits [16k+15:16k], so pixel 0 is in the LSBs.
- chunk_axis_valid  output  1  AXIS valid.
- chunk_axis_last  output  1  marks the last word of a frame.
- chunk_axis_ready  input  1  AXIS ready from the downstream FIFO.
- overflow_out  output  1  sticky; a completed word was dropped.
- resync_out  output  1  sticky; a frame_start arrived mid-frame.
- dropped_count_out  output  16  saturating count of dropped words.

Behaviour:
- Reset (synchronous, rst_in=1 at a clock edge):
  - All outputs go to 0.
  - Internal state: state=WAIT_SOF, slot index=0, word count=0, pack register=0.
  - Reset mid-operation discards any partial word and any held output word.
- State machine:
  - WAIT_SOF: pixels are ignored until pixel_valid_in && frame_start_in. That pixel is written to slot 0, slot becomes 1, word count=0, and the state moves to PACK.
  - PACK: each valid pixel is written to the current slot and the slot increments modulo 8.
  - Writing slot 7 completes a word; the completed word is the 7 held pixels plus the current pixel, combined combinationally.
- Word completion:
  - Load to the output register happens if (!chunk_axis_valid) or (chunk_axis_valid && chunk_axis_ready).
  - On load: chunk_axis_valid=1 on the next cycle; chunk_axis_last=(word count == FRAME_WORDS-1).
  - Latency: the word is visible exactly one cycle after the 8th pixel is accepted.
  - Otherwise (output held and not draining): drop the word, set overflow_out, and increment dropped_count_out (saturating at 16'hFFFF). The held word stays unchanged.
  - Word count increments on every completion, loaded or dropped, so downstream addressing stays frame-aligned.
  - When the count reaches FRAME_WORDS-1 and completes: count wraps to 0, state returns to WAIT_SOF, and pixels until the next frame_start are ignored.
- AXIS rules:
  - chunk_axis_data and chunk_axis_last are stable while valid && !ready.
  - valid deasserts the cycle after a handshake unless a new word loads that same cycle; back-to-back words are permitted.
  - valid never depends combinationally on ready.
- frame_start in PACK (pixel_valid_in && frame_start_in):
  - The partial word is discarded, with no output for it.
  - The pixel goes to slot 0, slot=1, word count=0, and the state stays PACK.
  - resync_out is set unless slot==0 and word count==0.
  - An output word already held is unaffected and completes its handshake normally.
- frame_start on the pixel completing slot 7 is a resync. That pixel starts the new frame; the completing word is discarded.
- Sticky flags clear only on reset.
- Pixel gaps (pixel_valid_in=0) of any length leave all state unchanged.

Test Plan:
- Aligned frame, FRAME_WORDS=4, ready held 1, pixels 16'h0000..16'h001F contiguous with frame_start on the first:
  - 4 words out; word 0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000.
  - last=1 only on word 3; flags stay 0.
- Pre-SOF garbage: 5 valid pixels without frame_start, then an aligned frame -> output identical to the previous test; no flags set.
- Backpressure with FRAME_WORDS=4: ready=0 for 20 cycles during a contiguous frame:
  - word 0 is held stable; words 1 and 2 are dropped.
  - overflow_out=1, dropped_count_out=2.
  - on releasing ready, word 0 then word 3 (last=1) are delivered.
- Resync: frame_start after 11 pixels of a frame (word 0 already output):
  - resync_out=1; the 3 partial pixels are discarded.
  - the new frame produces 4 full words with last on the 4th.
- Gapped input: pixel_valid_in toggling 1/0 every cycle -> same data as the first test; each word appears one cycle after its 8th pixel.
- Reset mid-frame after 5 pixels, then an aligned frame -> no stale pixels in word 0; outputs all 0 during reset.

Source files
------------

// File: rtl/pixel_packer_if.sv
// AXI-Stream channel carrying packed 128-bit pixel words toward the DDR3 write FIFO.
interface pixel_packer_if;
    logic [127:0] data;
    logic         valid;
    logic         last;
    logic         ready;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/pixel_packer.sv
// Packs 8 consecutive RGB565 pixels into one 128-bit AXIS word, frame-aligned.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// WAIT_SOF | idle between frames; pixels dropped until a valid frame_start
// PACK     | filling slots 0..7; slot 7 completes a word (load or drop)
module pixel_packer #(
    parameter int FRAME_WORDS = 115200,
    parameter int COUNT_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [15:0]           pixel_data_in,
    input  logic                  pixel_valid_in,
    input  logic                  frame_start_in,
    pixel_packer_if.master        chunk_axis,
    output logic                  overflow_out,
    output logic                  resync_out,
    output logic [15:0]           dropped_count_out
);

    typedef enum logic {
        WAIT_SOF = 1'b0,
        PACK     = 1'b1
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_WORD = COUNT_WIDTH'(FRAME_WORDS - 1);

    state_t                  state_q, state_d;
    logic [2:0]              slot_q, slot_d;
    logic [COUNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    // Only 7 pixels are ever held; the 8th is merged combinationally on completion.
    logic [6:0][15:0]        pack_q, pack_d;
    logic [127:0]            out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    overflow_q, overflow_d;
    logic                    resync_q, resync_d;
    logic [15:0]             dropped_q, dropped_d;

    logic                    can_load;
    logic [127:0]            complete_word;

    assign can_load      = !out_valid_q || chunk_axis.ready;
    assign complete_word = {pixel_data_in, pack_q};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= WAIT_SOF;
            slot_q      <= 3'd0;
            word_cnt_q  <= '0;
            pack_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
            resync_q    <= 1'b0;
            dropped_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            word_cnt_q  <= word_cnt_d;
            pack_q      <= pack_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
            resync_q    <= resync_d;
            dropped_q   <= dropped_d;
        end
    end

    // Next-state: slot filling, word completion/drop, frame alignment and resync.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        word_cnt_d  = word_cnt_q;
        pack_d      = pack_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !chunk_axis.ready;
        out_last_d  = out_last_q;
        overflow_d  = overflow_q;
        resync_d    = resync_q;
        dropped_d   = dropped_q;

        case (state_q)
            WAIT_SOF: begin
                if (pixel_valid_in && frame_start_in) begin
                    pack_d[0]  = pixel_data_in;
                    slot_d     = 3'd1;
                    word_cnt_d = '0;
                    state_d    = PACK;
                end
            end
            PACK: begin
                if (pixel_valid_in) begin
                    if (frame_start_in) begin
                        // New frame wins over any partial or completing word.
                        pack_d[0]  = pixel_data_in;
                        slot_d     = 3'd1;
                        word_cnt_d = '0;
                        if ((slot_q != 3'd0) || (word_cnt_q != '0)) begin
                            resync_d = 1'b1;
                        end
                    end else if (slot_q == 3'd7) begin
                        slot_d = 3'd0;
                        if (can_load) begin
                            out_data_d  = complete_word;
                            out_valid_d = 1'b1;
                            out_last_d  = (word_cnt_q == LAST_WORD);
                        end else begin
                            overflow_d = 1'b1;
                            if (dropped_q != 16'hFFFF) begin
                                dropped_d = dropped_q + 16'd1;
                            end
                        end
                        // Count dropped words too so addressing stays frame-aligned.
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d = '0;
                            state_d    = WAIT_SOF;
                        end else begin
                            word_cnt_d = word_cnt_q + COUNT_WIDTH'(1);
                        end
                    end else begin
                        for (int k = 0; k < 7; k++) begin
                            if (slot_q == 3'(k)) begin
                                pack_d[k] = pixel_data_in;
                            end
                        end
                        slot_d = slot_q + 3'd1;
                    end
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    assign chunk_axis.data   = out_data_q;
    assign chunk_axis.valid  = out_valid_q;
    assign chunk_axis.last   = out_last_q;
    assign overflow_out      = overflow_q;
    assign resync_out        = resync_q;
    assign dropped_count_out = dropped_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer with a 4-word frame.
module tb_pixel_packer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] pixel_data_in;
    logic        pixel_valid_in;
    logic        frame_start_in;
    logic        overflow_out;
    logic        resync_out;
    logic [15:0] dropped_count_out;

    pixel_packer_if chunk_axis ();

    pixel_packer #(
        .FRAME_WORDS(4),
        .COUNT_WIDTH(17)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .pixel_data_in     (pixel_data_in),
        .pixel_valid_in    (pixel_valid_in),
        .frame_start_in    (frame_start_in),
        .chunk_axis        (chunk_axis),
        .overflow_out      (overflow_out),
        .resync_out        (resync_out),
        .dropped_count_out (dropped_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [127:0] d;
        logic         l;
        int           c;
    } hs_t;

    hs_t hs_q[$];
    int  acc_cyc[$];
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    hs_t h;

    // Inputs change just after posedge, so the negedge sees what the next edge samples.
    always @(negedge clk_in) begin
        cyc++;
        if (!rst_in && pixel_valid_in) acc_cyc.push_back(cyc);
        if (chunk_axis.valid && chunk_axis.ready) begin
            h.d = chunk_axis.data;
            h.l = chunk_axis.last;
            h.c = cyc;
            hs_q.push_back(h);
        end
    end

    function automatic logic [127:0] exp_word(input logic [15:0] base);
        logic [127:0] w;
        for (int k = 0; k < 8; k++) w[16*k +: 16] = base + 16'(k);
        return w;
    endfunction

    task automatic send_px(input logic [15:0] p, input logic sof);
        @(posedge clk_in); #1;
        pixel_valid_in = 1'b1;
        pixel_data_in  = p;
        frame_start_in = sof;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in); #1;
            pixel_valid_in = 1'b0;
            frame_start_in = 1'b0;
            pixel_data_in  = 16'h0;
        end
    endtask

    task automatic send_frame(input logic [15:0] base);
        for (int i = 0; i < 32; i++) send_px(base + 16'(i), i == 0);
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        pixel_valid_in = 1'b0; frame_start_in = 1'b0; pixel_data_in = 16'h0;
        chunk_axis.ready = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        vectors++;
        if ({chunk_axis.valid, chunk_axis.last, overflow_out, resync_out} !== 4'b0 ||
            chunk_axis.data !== 128'h0 || dropped_count_out !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b last=%b ovf=%b rsy=%b drop=%h data=%h required all 0",
                     chunk_axis.valid, chunk_axis.last, overflow_out, resync_out, dropped_count_out, chunk_axis.data);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_aligned;
        hs_q.delete();
        send_frame(16'h0000);
        idle(4);
        vectors++;
        if (hs_q.size() !== 4) begin
            miscompares++; $display("FAIL aligned_count: got %0d words required 4", hs_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (hs_q[k].d !== exp_word(16'(8*k)) || hs_q[k].l !== (k == 3)) begin
                    miscompares++;
                    $display("FAIL aligned_word%0d: got %h last=%b required %h last=%b",
                             k, hs_q[k].d, hs_q[k].l, exp_word(16'(8*k)), k == 3);
                end
            end
        end
        vectors++;
        if (overflow_out !== 1'b0 || resync_out !== 1'b0 || dropped_count_out !== 16'h0) begin
            miscompares++;
            $display("FAIL aligned_flags: ovf=%b rsy=%b drop=%h required 0", overflow_out, resync_out, dropped_count_out);
        end
    endtask

    task automatic test_pre_sof;
        hs_q.delete();
        for (int i = 0; i < 5; i++) send_px(16'hAA00 + 16'(i), 1'b0);
        send_frame(16'h0000);
        idle(4);
        vectors++;
        if (hs_q.size() !== 4) begin
            miscompares++; $display("FAIL presof_count: got %0d words required 4", hs_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (hs_q[k].d !== exp_word(16'(8*k)) || hs_q[k].l !== (k == 3)) begin
                    miscompares++;
                    $display("FAIL presof_word%0d: got %h last=%b required %h last=%b",
                             k, hs_q[k].d, hs_q[k].l, exp_word(16'(8*k)), k == 3);
                end
            end
        end
        vectors++;
        if (overflow_out !== 1'b0 || resync_out !== 1'b0) begin
            miscompares++; $display("FAIL presof_flags: ovf=%b rsy=%b required 0", overflow_out, resync_out);
        end
    endtask

    task automatic test_gapped;
        hs_q.delete();
        acc_cyc.delete();
        for (int i = 0; i < 32; i++) begin
            send_px(16'(i), i == 0);
            idle(1);
        end
        idle(3);
        vectors++;
        if (hs_q.size() !== 4 || acc_cyc.size() !== 32) begin
            miscompares++;
            $display("FAIL gapped_count: got %0d words %0d pixels required 4 and 32", hs_q.size(), acc_cyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (hs_q[k].d !== exp_word(16'(8*k)) || hs_q[k].l !== (k == 3)) begin
                    miscompares++;
                    $display("FAIL gapped_word%0d: got %h last=%b required %h last=%b",
                             k, hs_q[k].d, hs_q[k].l, exp_word(16'(8*k)), k == 3);
                end
                vectors++;
                if (hs_q[k].c !== acc_cyc[8*k+7] + 1) begin
                    miscompares++;
                    $display("FAIL gapped_latency%0d: word at cycle %0d required %0d",
                             k, hs_q[k].c, acc_cyc[8*k+7] + 1);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] base;
        base = 16'h0100;
        hs_q.delete();
        for (int i = 0; i < 32; i++) begin
            @(posedge clk_in); #1;
            if (i >= 8 && i <= 24) begin
                vectors++;
                if (chunk_axis.valid !== 1'b1 || chunk_axis.data !== exp_word(base) || chunk_axis.last !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_hold@%0d: valid=%b last=%b data=%h required 1 0 %h",
                             i, chunk_axis.valid, chunk_axis.last, chunk_axis.data, exp_word(base));
                end
            end
            chunk_axis.ready = !(i >= 4 && i <= 23);
            pixel_valid_in = 1'b1;
            pixel_data_in  = base + 16'(i);
            frame_start_in = (i == 0);
        end
        idle(4);
        vectors++;
        if (hs_q.size() !== 2) begin
            miscompares++; $display("FAIL bp_count: got %0d words required 2", hs_q.size());
        end else begin
            vectors++;
            if (hs_q[0].d !== exp_word(base) || hs_q[0].l !== 1'b0) begin
                miscompares++; $display("FAIL bp_word0: got %h last=%b required %h last=0", hs_q[0].d, hs_q[0].l, exp_word(base));
            end
            vectors++;
            if (hs_q[1].d !== exp_word(base + 16'd24) || hs_q[1].l !== 1'b1) begin
                miscompares++; $display("FAIL bp_word3: got %h last=%b required %h last=1", hs_q[1].d, hs_q[1].l, exp_word(base + 16'd24));
            end
        end
        vectors++;
        if (overflow_out !== 1'b1 || dropped_count_out !== 16'd2 || resync_out !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_flags: ovf=%b drop=%0d rsy=%b required 1 2 0", overflow_out, dropped_count_out, resync_out);
        end
    endtask

    task automatic test_resync;
        hs_q.delete();
        for (int i = 0; i < 11; i++) send_px(16'h0200 + 16'(i), i == 0);
        idle(1);
        vectors++;
        if (resync_out !== 1'b0) begin
            miscompares++; $display("FAIL resync_before: got %b required 0", resync_out);
        end
        send_frame(16'h0300);
        idle(4);
        vectors++;
        if (resync_out !== 1'b1) begin
            miscompares++; $display("FAIL resync_flag: got %b required 1", resync_out);
        end
        vectors++;
        if (hs_q.size() !== 5) begin
            miscompares++; $display("FAIL resync_count: got %0d words required 5", hs_q.size());
        end else begin
            vectors++;
            if (hs_q[0].d !== exp_word(16'h0200) || hs_q[0].l !== 1'b0) begin
                miscompares++; $display("FAIL resync_old0: got %h last=%b required %h last=0", hs_q[0].d, hs_q[0].l, exp_word(16'h0200));
            end
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (hs_q[k+1].d !== exp_word(16'h0300 + 16'(8*k)) || hs_q[k+1].l !== (k == 3)) begin
                    miscompares++;
                    $display("FAIL resync_new%0d: got %h last=%b required %h last=%b",
                             k, hs_q[k+1].d, hs_q[k+1].l, exp_word(16'h0300 + 16'(8*k)), k == 3);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        hs_q.delete();
        for (int i = 0; i < 5; i++) send_px(16'h0400 + 16'(i), i == 0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        pixel_valid_in = 1'b0; frame_start_in = 1'b0;
        repeat (2) begin
            @(posedge clk_in); #1;
            vectors++;
            if ({chunk_axis.valid, chunk_axis.last, overflow_out, resync_out} !== 4'b0 ||
                chunk_axis.data !== 128'h0 || dropped_count_out !== 16'h0) begin
                miscompares++;
                $display("FAIL midreset_outputs: valid=%b ovf=%b rsy=%b drop=%h data=%h required all 0",
                         chunk_axis.valid, overflow_out, resync_out, dropped_count_out, chunk_axis.data);
            end
        end
        rst_in = 1'b0;
        hs_q.delete();
        send_frame(16'h0000);
        idle(4);
        vectors++;
        if (hs_q.size() !== 4) begin
            miscompares++; $display("FAIL midreset_count: got %0d words required 4", hs_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (hs_q[k].d !== exp_word(16'(8*k)) || hs_q[k].l !== (k == 3)) begin
                    miscompares++;
                    $display("FAIL midreset_word%0d: got %h last=%b required %h last=%b",
                             k, hs_q[k].d, hs_q[k].l, exp_word(16'(8*k)), k == 3);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_aligned;
        test_pre_sof;
        test_gapped;
        test_backpressure;
        test_resync;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
